// File: rtl/riscv_bht.sv
// riscv_bht: direct-mapped branch history/target table with 2-bit saturating counters.
// Fetch lookup is combinational; training and the mispredict redirect are registered.
module riscv_bht #(
  parameter int XLEN    = 64,
  parameter int ENTRIES = 64
) (
  input  logic            i_riscv_bht_clk,
  input  logic            i_riscv_bht_rst,
  input  logic [XLEN-1:0] i_riscv_bht_fetch_pc,
  output logic            o_riscv_bht_pred_taken,
  output logic [XLEN-1:0] o_riscv_bht_pred_pc,
  input  logic            i_riscv_bht_upd_valid,
  input  logic [XLEN-1:0] i_riscv_bht_upd_pc,
  input  logic            i_riscv_bht_upd_taken,
  input  logic [XLEN-1:0] i_riscv_bht_upd_target,
  input  logic            i_riscv_bht_upd_pred_taken,
  input  logic [XLEN-1:0] i_riscv_bht_upd_pred_pc,
  output logic            o_riscv_bht_mispredict,
  output logic [XLEN-1:0] o_riscv_bht_redirect_pc
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = XLEN - IDX_W - 2;
  localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } ctr_t;

  logic             tbl_valid  [ENTRIES];
  ctr_t             tbl_ctr    [ENTRIES];
  logic [TAG_W-1:0] tbl_tag    [ENTRIES];
  logic [XLEN-1:0]  tbl_target [ENTRIES];

  logic [IDX_W-1:0] fetch_idx;
  logic [TAG_W-1:0] fetch_tag;
  logic             fetch_hit;
  logic [XLEN-1:0]  fetch_seq;

  logic [IDX_W-1:0] upd_idx;
  logic [TAG_W-1:0] upd_tag;
  logic             upd_hit;
  logic [XLEN-1:0]  upd_seq;
  logic [XLEN-1:0]  actual_next;
  logic             mispredict_cond;

  // The carried prediction bit is informational only; the pc comparison decides.
  logic             unused_pred_taken;

  function automatic ctr_t ctr_step(input ctr_t c, input logic taken);
    ctr_t n;
    case (c)
      SNT:     n = taken ? WNT : SNT;
      WNT:     n = taken ? WT  : SNT;
      WT:      n = taken ? ST  : WNT;
      default: n = taken ? ST  : WT;
    endcase
    return n;
  endfunction

  assign unused_pred_taken = i_riscv_bht_upd_pred_taken;

  assign fetch_idx = i_riscv_bht_fetch_pc[IDX_W+1:2];
  assign fetch_tag = i_riscv_bht_fetch_pc[XLEN-1:IDX_W+2];
  assign fetch_hit = tbl_valid[fetch_idx] && (tbl_tag[fetch_idx] == fetch_tag);
  assign fetch_seq = i_riscv_bht_fetch_pc + PC_STEP;

  always_comb begin
    o_riscv_bht_pred_taken = 1'b0;
    o_riscv_bht_pred_pc    = fetch_seq;
    if (fetch_hit && (tbl_ctr[fetch_idx] inside {WT, ST})) begin
      o_riscv_bht_pred_taken = 1'b1;
      o_riscv_bht_pred_pc    = tbl_target[fetch_idx];
    end
  end

  assign upd_idx         = i_riscv_bht_upd_pc[IDX_W+1:2];
  assign upd_tag         = i_riscv_bht_upd_pc[XLEN-1:IDX_W+2];
  assign upd_hit         = tbl_valid[upd_idx] && (tbl_tag[upd_idx] == upd_tag);
  assign upd_seq         = i_riscv_bht_upd_pc + PC_STEP;
  assign actual_next     = i_riscv_bht_upd_taken ? i_riscv_bht_upd_target : upd_seq;
  assign mispredict_cond = i_riscv_bht_upd_valid && (actual_next != i_riscv_bht_upd_pred_pc);

  // Not-taken misses never allocate, so cold branches keep falling through.
  always_ff @(posedge i_riscv_bht_clk) begin
    if (i_riscv_bht_rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        tbl_valid[i]  <= 1'b0;
        tbl_ctr[i]    <= WNT;
        tbl_tag[i]    <= '0;
        tbl_target[i] <= '0;
      end
    end else if (i_riscv_bht_upd_valid) begin
      if (upd_hit) begin
        tbl_ctr[upd_idx] <= ctr_step(tbl_ctr[upd_idx], i_riscv_bht_upd_taken);
        if (i_riscv_bht_upd_taken) begin
          tbl_target[upd_idx] <= i_riscv_bht_upd_target;
        end
      end else if (i_riscv_bht_upd_taken) begin
        tbl_valid[upd_idx]  <= 1'b1;
        tbl_tag[upd_idx]    <= upd_tag;
        tbl_target[upd_idx] <= i_riscv_bht_upd_target;
        tbl_ctr[upd_idx]    <= WT;
      end
    end
  end

  // redirect_pc keeps its last value between pulses.
  always_ff @(posedge i_riscv_bht_clk) begin
    if (i_riscv_bht_rst) begin
      o_riscv_bht_mispredict  <= 1'b0;
      o_riscv_bht_redirect_pc <= '0;
    end else if (mispredict_cond) begin
      o_riscv_bht_mispredict  <= 1'b1;
      o_riscv_bht_redirect_pc <= actual_next;
    end else begin
      o_riscv_bht_mispredict  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_riscv_bht.sv
// tb_riscv_bht: randomized scoreboard bench for riscv_bht against a table-level
// reference model; lookup and redirect expectations are checked by a separate monitor.
module tb_riscv_bht;

  localparam int XLEN    = 64;
  localparam int ENTRIES = 64;
  localparam int IDX_W   = $clog2(ENTRIES);

  typedef struct {
    int          due;
    logic        flag;
    logic [63:0] pc;
  } exp_t;

  logic        clk;
  logic        rst;
  logic [63:0] fetchPc;
  logic        predTaken;
  logic [63:0] predPc;
  logic        updValid;
  logic [63:0] updPc;
  logic        updTaken;
  logic [63:0] updTarget;
  logic        updPredTaken;
  logic [63:0] updPredPc;
  logic        mispredict;
  logic [63:0] redirectPc;

  int compared   = 0;
  int mismatched = 0;
  int cyc        = 0;

  exp_t lookQ[$];
  exp_t misQ[$];

  bit          mValid  [ENTRIES];
  logic [63:0] mTag    [ENTRIES];
  logic [63:0] mTarget [ENTRIES];
  int          mCtr    [ENTRIES];
  logic [63:0] mRedir;
  bit          known = 0;

  riscv_bht #(.XLEN(XLEN), .ENTRIES(ENTRIES)) dut (
    .i_riscv_bht_clk            (clk),
    .i_riscv_bht_rst            (rst),
    .i_riscv_bht_fetch_pc       (fetchPc),
    .o_riscv_bht_pred_taken     (predTaken),
    .o_riscv_bht_pred_pc        (predPc),
    .i_riscv_bht_upd_valid      (updValid),
    .i_riscv_bht_upd_pc         (updPc),
    .i_riscv_bht_upd_taken      (updTaken),
    .i_riscv_bht_upd_target     (updTarget),
    .i_riscv_bht_upd_pred_taken (updPredTaken),
    .i_riscv_bht_upd_pred_pc    (updPredPc),
    .o_riscv_bht_mispredict     (mispredict),
    .o_riscv_bht_redirect_pc    (redirectPc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int idxOf(input logic [63:0] pc);
    return int'((pc >> 2) % ENTRIES);
  endfunction

  function automatic logic [63:0] tagOf(input logic [63:0] pc);
    return pc >> (IDX_W + 2);
  endfunction

  // Reference prediction: taken only on a hit whose counter is in the upper half.
  task automatic predict(input logic [63:0] pc, output logic t, output logic [63:0] npc);
    int i;
    i = idxOf(pc);
    if (mValid[i] && mTag[i] == tagOf(pc) && mCtr[i] >= 2) begin
      t   = 1'b1;
      npc = mTarget[i];
    end else begin
      t   = 1'b0;
      npc = pc + 64'd4;
    end
  endtask

  task automatic checkOutput(input string name, input logic [63:0] got, input logic [63:0] want);
    compared++;
    if (got !== want) begin
      mismatched++;
      $display("[TB] FAIL %s at cycle %0d: got %h expected %h", name, cyc, got, want);
    end
  endtask

  task automatic applyStimulus(input logic r, input logic [63:0] fpc, input logic uv,
                               input logic [63:0] upc, input logic ut,
                               input logic [63:0] utgt, input logic [63:0] uppc);
    exp_t        e;
    logic        pt;
    logic [63:0] ppc;
    logic [63:0] actual;
    int          i;
    bit          hit;
    @(posedge clk);
    #1;
    rst          = r;
    fetchPc      = fpc;
    updValid     = uv;
    updPc        = upc;
    updTaken     = ut;
    updTarget    = utgt;
    updPredPc    = uppc;
    updPredTaken = $urandom_range(0, 1) == 1;
    if (known) begin
      predict(fpc, pt, ppc);
      e.due  = cyc;
      e.flag = pt;
      e.pc   = ppc;
      lookQ.push_back(e);
    end
    e.flag = 1'b0;
    if (r) begin
      for (int k = 0; k < ENTRIES; k++) begin
        mValid[k]  = 0;
        mCtr[k]    = 1;
        mTag[k]    = '0;
        mTarget[k] = '0;
      end
      mRedir = '0;
      known  = 1;
    end else if (uv) begin
      actual = ut ? utgt : upc + 64'd4;
      if (actual != uppc) begin
        e.flag = 1'b1;
        mRedir = actual;
      end
      i   = idxOf(upc);
      hit = mValid[i] && mTag[i] == tagOf(upc);
      if (hit) begin
        mCtr[i] = ut ? ((mCtr[i] < 3) ? mCtr[i] + 1 : 3) : ((mCtr[i] > 0) ? mCtr[i] - 1 : 0);
        if (ut) mTarget[i] = utgt;
      end else if (ut) begin
        mValid[i]  = 1;
        mTag[i]    = tagOf(upc);
        mTarget[i] = utgt;
        mCtr[i]    = 2;
      end
    end
    if (known) begin
      e.due = cyc + 1;
      e.pc  = mRedir;
      misQ.push_back(e);
    end
  endtask

  task automatic lookupOnly(input logic [63:0] fpc);
    applyStimulus(1'b0, fpc, 1'b0, 64'h0, 1'b0, 64'h0, 64'h0);
  endtask

  task automatic train(input logic [63:0] fpc, input logic [63:0] upc, input logic ut,
                       input logic [63:0] utgt, input logic [63:0] uppc);
    applyStimulus(1'b0, fpc, 1'b1, upc, ut, utgt, uppc);
  endtask

  function automatic logic [63:0] randPc();
    logic [63:0] p;
    p = (64'($urandom_range(0, 3)) << (IDX_W + 2)) | (64'($urandom_range(0, 7)) << 2)
        | 64'($urandom_range(0, 3));
    if ($urandom_range(0, 19) == 0) p = 64'hFFFF_FFFF_FFFF_FFFC;
    if ($urandom_range(0, 29) == 0) p = {$urandom, $urandom};
    return p;
  endfunction

  // Monitor: drains every expectation that falls due in the current cycle.
  always @(negedge clk) begin
    while (lookQ.size() > 0 && lookQ[0].due <= cyc) begin
      exp_t e;
      e = lookQ.pop_front();
      checkOutput("pred_taken", 64'(predTaken), 64'(e.flag));
      checkOutput("pred_pc", predPc, e.pc);
    end
    while (misQ.size() > 0 && misQ[0].due <= cyc) begin
      exp_t e;
      e = misQ.pop_front();
      checkOutput("mispredict", 64'(mispredict), 64'(e.flag));
      checkOutput("redirect_pc", redirectPc, e.pc);
    end
  end

  initial begin
    logic        pt;
    logic [63:0] ppc;
    logic [63:0] upc;
    logic [63:0] tgt;
    logic        ut;
    rst = 1'b1; fetchPc = '0; updValid = 1'b0; updPc = '0; updTaken = 1'b0;
    updTarget = '0; updPredTaken = 1'b0; updPredPc = '0;

    applyStimulus(1'b1, 64'h1000, 1'b0, 64'h0, 1'b0, 64'h0, 64'h0);
    applyStimulus(1'b1, 64'h1000, 1'b0, 64'h0, 1'b0, 64'h0, 64'h0);
    lookupOnly(64'h1000);

    train(64'h1000, 64'h1000, 1'b1, 64'h2000, 64'h1004);
    lookupOnly(64'h1000);
    for (int k = 0; k < 3; k++) train(64'h1000, 64'h1000, 1'b1, 64'h2000, 64'h2000);
    train(64'h1000, 64'h1000, 1'b0, 64'h2000, 64'h1004);
    lookupOnly(64'h1000);
    train(64'h1000, 64'h1000, 1'b0, 64'h2000, 64'h2000);
    lookupOnly(64'h1000);
    lookupOnly(64'h1004);

    train(64'h1000, 64'h1000, 1'b1, 64'h2000, 64'h1004);
    train(64'h1100, 64'h1100, 1'b1, 64'h3000, 64'h1104);
    lookupOnly(64'h1000);
    lookupOnly(64'h1100);

    train(64'h1000, 64'h1000, 1'b1, 64'h4000, 64'h1004);
    lookupOnly(64'h1000);
    train(64'h1000, 64'h1000, 1'b1, 64'h5000, 64'h4000);
    lookupOnly(64'h1000);
    lookupOnly(64'hFFFF_FFFF_FFFF_FFFC);
    train(64'h1000, 64'h2000, 1'b0, 64'h0, 64'h2004);
    lookupOnly(64'h2000);

    applyStimulus(1'b1, 64'h1000, 1'b1, 64'h1000, 1'b1, 64'h6000, 64'h1004);
    lookupOnly(64'h1000);
    lookupOnly(64'h1100);

    for (int n = 0; n < 600; n++) begin
      upc = randPc();
      ut  = $urandom_range(0, 2) != 0;
      tgt = ($urandom_range(0, 3) == 0) ? {$urandom, $urandom} : randPc();
      predict(upc, pt, ppc);
      if ($urandom_range(0, 9) < 4) ppc = ($urandom_range(0, 1) == 1) ? tgt : upc + 64'd4;
      if ($urandom_range(0, 99) == 0) begin
        applyStimulus(1'b1, randPc(), 1'b1, upc, ut, tgt, ppc);
      end else begin
        applyStimulus(1'b0, ($urandom_range(0, 4) == 0) ? upc : randPc(),
                      $urandom_range(0, 3) != 0, upc, ut, tgt, ppc);
      end
    end

    updValid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    if (lookQ.size() != 0 || misQ.size() != 0) begin
      compared++;
      mismatched++;
      $display("[TB] FAIL drain: got %0d pending expected 0", lookQ.size() + misQ.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
